// File: rtl/graph_pkg.sv
// Shared definitions for the CSR graph image: loader FSM states, default
// region bases and the header field layout (shared with graph_fetch).
package graph_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    POS    = 3'd2,
    NEIGH  = 3'd3,
    ROWIDX = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_e;

  localparam int unsigned ROW_BASE_DEF  = 0;
  localparam int unsigned DATA_BASE_DEF = 1024;

  // Header word: degree in [HDR_DEG_LSB +: HDR_DEG_W], remaining bits ignored.
  localparam int unsigned HDR_DEG_LSB = 0;
  localparam int unsigned HDR_DEG_W   = 16;

endpackage

// File: rtl/graph_writer_if.sv
// Single-word memory write port: addr/data qualified by valid, accepted when
// ready is high in the same cycle.
//   master: drives addr, data, valid; samples ready
//   slave : samples addr, data, valid; drives ready
interface graph_writer_if;
  logic [31:0] addr;
  logic [31:0] data;
  logic        valid;
  logic        ready;

  modport master (output addr, output data, output valid, input ready);
  modport slave  (input addr, input data, input valid, output ready);
endinterface

// File: rtl/graph_wr_slot.sv
// Single-entry registered write slot. A load captures addr/data and raises
// valid; the entry is held stable until the memory side accepts it.
//   clk_in, rst_in : clock, asynchronous active-low reset
//   load_in        : capture addr_in/data_in (only legal when free_out is high)
//   free_out       : slot can take a new entry this cycle
//   mem            : write port (master side)
module graph_wr_slot (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          load_in,
  input  logic [31:0]   addr_in,
  input  logic [31:0]   data_in,
  output logic          free_out,
  graph_writer_if.master mem
);

  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;

  assign free_out = !valid_q || mem.ready;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load_in) begin
      valid_d = 1'b1;
      addr_d  = addr_in;
      data_d  = data_in;
    end else if (mem.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign mem.valid = valid_q;
  assign mem.addr  = addr_q;
  assign mem.data  = data_q;

endmodule

// File: rtl/graph_writer.sv
// Streaming CSR graph loader. Consumes vertex records (header, DIM position
// words, N neighbour ids) and writes each record into the data region plus
// a row-index entry pointing at it.
//   clk_in, rst_in          : clock, asynchronous active-low reset
//   start_in                : arm loader / clear counters (IDLE, DONE, ERR)
//   word_in/valid/last/ready: input word stream
//   mem_addr/data/valid_out, mem_ready_in : memory write port
//   vertex_count_out        : vertices whose row-index write was accepted
//   done_out, error_out, state_out : status
module graph_writer
  import graph_pkg::*;
#(
  parameter int unsigned DIM          = 2,
  parameter int unsigned MAX_DEG      = 16,
  parameter int unsigned MAX_VERTICES = 1024,
  parameter int unsigned ROW_BASE     = ROW_BASE_DEF,
  parameter int unsigned DATA_BASE    = DATA_BASE_DEF,
  parameter int unsigned DATA_DEPTH   = 4096
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [31:0] word_in,
  input  logic        word_valid_in,
  input  logic        last_in,
  output logic        word_ready_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_data_out,
  output logic        mem_valid_out,
  input  logic        mem_ready_in,
  output logic [15:0] vertex_count_out,
  output logic        done_out,
  output logic        error_out,
  output logic [2:0]  state_out
);

  state_e      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] vid_q, vid_d;
  logic [15:0] vcount_q, vcount_d;
  logic [31:0] wptr_q, wptr_d;
  logic [31:0] rec_ptr_q, rec_ptr_d;
  logic        last_rec_q, last_rec_d;
  logic        row_pend_q, row_pend_d;
  logic        err_pend_q, err_pend_d;

  logic        slot_load, slot_free;
  logic [31:0] slot_addr, slot_data;
  logic        accept, in_load_state, hdr_bad;
  logic [15:0] hdr_n;
  logic [31:0] rec_end;

  graph_writer_if mem_if ();

  graph_wr_slot u_slot (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load_in  (slot_load),
    .addr_in  (slot_addr),
    .data_in  (slot_data),
    .free_out (slot_free),
    .mem      (mem_if.master)
  );

  assign mem_if.ready  = mem_ready_in;
  assign mem_addr_out  = mem_if.addr;
  assign mem_data_out  = mem_if.data;
  assign mem_valid_out = mem_if.valid;

  assign hdr_n   = word_in[HDR_DEG_LSB +: HDR_DEG_W];
  assign rec_end = wptr_q + 32'(1 + DIM) + {16'd0, hdr_n};
  assign hdr_bad = ({16'd0, hdr_n} > 32'(MAX_DEG)) ||
                   (rec_end > 32'(DATA_DEPTH)) ||
                   ({16'd0, vid_q} == 32'(MAX_VERTICES));

  assign in_load_state  = (state_q == HDR) || (state_q == POS) || (state_q == NEIGH);
  // err_pend blocks further input while a word carrying a misplaced last drains.
  assign word_ready_out = in_load_state && slot_free && !err_pend_q;
  assign accept         = word_valid_in && word_ready_out;

  // vid advances when the row-index write is issued so the next header can be
  // taken while that write drains (one bubble per vertex); vcount advances
  // only once the write is accepted.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    vid_d      = vid_q;
    vcount_d   = vcount_q;
    wptr_d     = wptr_q;
    rec_ptr_d  = rec_ptr_q;
    last_rec_d = last_rec_q;
    row_pend_d = row_pend_q;
    err_pend_d = err_pend_q;
    slot_load  = 1'b0;
    slot_addr  = 32'(DATA_BASE) + wptr_q;
    slot_data  = word_in;

    if (row_pend_q && mem_if.valid && mem_ready_in) begin
      vcount_d   = vcount_q + 16'd1;
      row_pend_d = 1'b0;
    end

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_in) begin
          state_d    = HDR;
          vid_d      = '0;
          vcount_d   = '0;
          wptr_d     = '0;
          row_pend_d = 1'b0;
          err_pend_d = 1'b0;
        end
      end
      HDR: begin
        if (accept) begin
          if (hdr_bad) begin
            state_d = ERR;
          end else begin
            slot_load  = 1'b1;
            slot_data  = {16'd0, hdr_n};
            n_d        = hdr_n;
            rec_ptr_d  = wptr_q;
            wptr_d     = wptr_q + 32'd1;
            idx_d      = '0;
            state_d    = POS;
            err_pend_d = last_in;
          end
        end
      end
      POS: begin
        if (accept) begin
          slot_load = 1'b1;
          wptr_d    = wptr_q + 32'd1;
          if (idx_q == 16'(DIM - 1)) begin
            idx_d = '0;
            if (n_q == '0) begin
              state_d    = ROWIDX;
              last_rec_d = last_in;
            end else begin
              state_d    = NEIGH;
              err_pend_d = last_in;
            end
          end else begin
            idx_d      = idx_q + 16'd1;
            err_pend_d = last_in;
          end
        end
      end
      NEIGH: begin
        if (accept) begin
          slot_load = 1'b1;
          wptr_d    = wptr_q + 32'd1;
          if (idx_q == n_q - 16'd1) begin
            state_d    = ROWIDX;
            last_rec_d = last_in;
          end else begin
            idx_d      = idx_q + 16'd1;
            err_pend_d = last_in;
          end
        end
      end
      ROWIDX: begin
        if (!row_pend_q) begin
          if (slot_free) begin
            slot_load  = 1'b1;
            slot_addr  = 32'(ROW_BASE) + {16'd0, vid_q};
            slot_data  = rec_ptr_q;
            vid_d      = vid_q + 16'd1;
            row_pend_d = 1'b1;
            if (!last_rec_q) state_d = HDR;
          end
        end else if (mem_ready_in) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (err_pend_q && mem_if.valid && mem_ready_in) begin
      state_d    = ERR;
      err_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      vid_q      <= '0;
      vcount_q   <= '0;
      wptr_q     <= '0;
      rec_ptr_q  <= '0;
      last_rec_q <= 1'b0;
      row_pend_q <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      vid_q      <= vid_d;
      vcount_q   <= vcount_d;
      wptr_q     <= wptr_d;
      rec_ptr_q  <= rec_ptr_d;
      last_rec_q <= last_rec_d;
      row_pend_q <= row_pend_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign vertex_count_out = vcount_q;
  assign done_out         = (state_q == DONE);
  assign error_out        = (state_q == ERR);
  assign state_out        = state_q;

endmodule
